// File: rtl/fetch_pkg.sv
// Shared constants for the fetch stage: FSM state encodings and the
// instruction words the stage recognises or injects.
package fetch_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_BOOT = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_HALT = 2'd2;

  localparam logic [31:0] NOP_INSN  = 32'h0000_0013;
  localparam logic [31:0] HALT_INSN = 32'h0000_0073;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: stall > halt > jump > branch > sequential increment.
// Redirect targets are word-aligned here; misaligned requests raise a strobe.
module pc_next_sel
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [31:0]       instr,
  input  logic              stall,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] next_pc_c,
  output logic              cnt_en_c,
  output logic              halt_c,
  output logic              misalign_c
);

  always_comb begin
    next_pc_c  = pc;
    cnt_en_c   = 1'b0;
    halt_c     = 1'b0;
    misalign_c = 1'b0;
    if (!stall) begin
      cnt_en_c = 1'b1;
      if (instr == HALT_INSN) begin
        halt_c = 1'b1;
      end else if (jump) begin
        next_pc_c  = {jump_target[ADDR_W-1:2], 2'b00};
        misalign_c = |jump_target[1:0];
      end else if (branch_taken) begin
        next_pc_c  = {branch_target[ADDR_W-1:2], 2'b00};
        misalign_c = |branch_target[1:0];
      end else begin
        next_pc_c = pc + ADDR_W'(4);
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// PC register and fetch control for the single-cycle core: BOOT bubble,
// RUN with zero-latency fetch, terminal HALT, sticky misalign, saturating count.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned          ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0,
  parameter int unsigned          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_instr,
  input  logic              stall,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [31:0]       instr_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              instr_valid,
  output logic              halted,
  output logic              misalign_err,
  output logic [CNT_W-1:0]  fetch_count
);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   pc, pc_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                mis, mis_nxt;

  logic [ADDR_W-1:0]   sel_pc_c;
  logic                sel_cnt_en_c;
  logic                sel_halt_c;
  logic                sel_misalign_c;

  pc_next_sel #(
    .ADDR_W (ADDR_W)
  ) u_sel (
    .pc            (pc),
    .instr         (imem_instr),
    .stall         (stall),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .next_pc_c     (sel_pc_c),
    .cnt_en_c      (sel_cnt_en_c),
    .halt_c        (sel_halt_c),
    .misalign_c    (sel_misalign_c)
  );

  // State, PC, counter and sticky flag; reset overrides every state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_BOOT;
      pc    <= RESET_PC;
      cnt   <= '0;
      mis   <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      cnt   <= cnt_nxt;
      mis   <= mis_nxt;
    end
  end

  // Next-state logic; only RUN lets the selector touch architectural state.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cnt_nxt   = cnt;
    mis_nxt   = mis;
    case (state)
      ST_BOOT: state_nxt = ST_RUN;
      ST_RUN: begin
        pc_nxt = sel_pc_c;
        if (sel_halt_c) begin
          state_nxt = ST_HALT;
        end
        if (sel_cnt_en_c && (cnt != '1)) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
        if (sel_misalign_c) begin
          mis_nxt = 1'b1;
        end
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_BOOT;
    endcase
  end

  // Instruction path stays combinational so RUN has zero fetch latency.
  assign imem_addr    = pc;
  assign pc_out       = pc;
  assign instr_valid  = (state == ST_RUN);
  assign instr_out    = (state == ST_RUN) ? imem_instr : NOP_INSN;
  assign halted       = (state == ST_HALT);
  assign misalign_err = mis;
  assign fetch_count  = cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a 16-bit-counter instance and a 4-bit-counter
// instance share stimulus, each reading its own port of one instruction memory.
module tb_fetch_unit;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] HALT = 32'h0000_0073;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        jump;
  logic [7:0]  jump_target;
  logic        branch_taken;
  logic [7:0]  branch_target;

  logic [31:0] mem [64];

  logic [7:0]  addr_a, pc_a, addr_b, pc_b;
  logic [31:0] instr_in_a, instr_a, instr_in_b, instr_b;
  logic        valid_a, halted_a, mis_a, valid_b, halted_b, mis_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign instr_in_a = mem[addr_a[7:2]];
  assign instr_in_b = mem[addr_b[7:2]];

  fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00), .CNT_W(16)) dut_a (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (addr_a),
    .imem_instr    (instr_in_a),
    .stall         (stall),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr_out     (instr_a),
    .pc_out        (pc_a),
    .instr_valid   (valid_a),
    .halted        (halted_a),
    .misalign_err  (mis_a),
    .fetch_count   (cnt_a)
  );

  fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00), .CNT_W(4)) dut_b (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (addr_b),
    .imem_instr    (instr_in_b),
    .stall         (stall),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr_out     (instr_b),
    .pc_out        (pc_b),
    .instr_valid   (valid_b),
    .halted        (halted_b),
    .misalign_err  (mis_b),
    .fetch_count   (cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = NOP;
    mem[0] = 32'h0000_7033;
    mem[1] = 32'h0010_0093;

    rst_n = 1'b0; stall = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    jump_target = 8'h00; branch_target = 8'h00;
    step(2);
    check("rst_addr",   32'(addr_a), 32'h00);
    check("rst_valid",  32'(valid_a), 32'h0);
    check("rst_instr",  instr_a, NOP);
    check("rst_halted", 32'(halted_a), 32'h0);
    check("rst_count",  32'(cnt_a), 32'h0);
    check("rst_mis",    32'(mis_a), 32'h0);

    // Cycle 0 after release is the BOOT bubble.
    rst_n = 1'b1;
    #1;
    check("boot_valid", 32'(valid_a), 32'h0);
    check("boot_addr",  32'(addr_a), 32'h00);
    step(1);
    check("c1_valid", 32'(valid_a), 32'h1);
    check("c1_instr", instr_a, 32'h0000_7033);
    check("c1_pc",    32'(pc_a), 32'h00);
    step(1);
    check("c2_instr", instr_a, 32'h0010_0093);
    check("c2_pc",    32'(pc_a), 32'h04);
    step(1);
    check("c3_pc",    32'(pc_a), 32'h08);
    check("c3_count", 32'(cnt_a), 32'd2);

    // Stall with a pending jump: nothing moves.
    stall = 1'b1; jump = 1'b1; jump_target = 8'h40;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("stall_pc",    32'(addr_a), 32'h08);
      check("stall_count", 32'(cnt_a), 32'd2);
    end
    stall = 1'b0; jump = 1'b0;
    step(1);
    check("unstall_pc",    32'(addr_a), 32'h0C);
    check("unstall_count", 32'(cnt_a), 32'd3);

    // Jump beats branch.
    jump = 1'b1; jump_target = 8'h40; branch_taken = 1'b1; branch_target = 8'h20;
    step(1);
    check("prio_pc",  32'(addr_a), 32'h40);
    check("prio_mis", 32'(mis_a), 32'h0);
    jump = 1'b0; branch_target = 8'h23;
    step(1);
    check("misbr_pc",    32'(addr_a), 32'h20);
    check("misbr_mis",   32'(mis_a), 32'h1);
    check("misbr_count", 32'(cnt_a), 32'd5);
    branch_taken = 1'b0;
    step(10);
    check("sticky_mis", 32'(mis_a), 32'h1);
    check("sticky_pc",  32'(addr_a), 32'h48);
    check("cnt15_a",    32'(cnt_a), 32'd15);
    check("cnt15_b",    32'(cnt_b), 32'd15);

    // PC wrap from 0xFC.
    jump = 1'b1; jump_target = 8'hFC;
    step(1);
    check("to_fc_pc", 32'(addr_a), 32'hFC);
    jump = 1'b0;
    step(1);
    check("wrap_pc",    32'(addr_a), 32'h00);
    check("wrap_cnt_a", 32'(cnt_a), 32'd17);
    check("sat_cnt_b",  32'(cnt_b), 32'd15);

    // Mid-run reset overrides a simultaneous jump.
    rst_n = 1'b0; jump = 1'b1; jump_target = 8'h80;
    step(1);
    check("mrst_pc",     32'(addr_a), 32'h00);
    check("mrst_cnt_a",  32'(cnt_a), 32'd0);
    check("mrst_cnt_b",  32'(cnt_b), 32'd0);
    check("mrst_mis",    32'(mis_a), 32'h0);
    check("mrst_halted", 32'(halted_a), 32'h0);
    check("mrst_valid",  32'(valid_a), 32'h0);

    // Straight-line run into a HALT at 0x4C.
    jump = 1'b0;
    mem[19] = HALT;
    rst_n = 1'b1;
    step(1);
    check("h_start_pc", 32'(addr_a), 32'h00);
    step(19);
    check("h_pc",    32'(addr_a), 32'h4C);
    check("h_valid", 32'(valid_a), 32'h1);
    check("h_instr", instr_a, HALT);
    check("h_count", 32'(cnt_a), 32'd19);
    step(1);
    check("hd_halted", 32'(halted_a), 32'h1);
    check("hd_valid",  32'(valid_a), 32'h0);
    check("hd_instr",  instr_a, NOP);
    check("hd_pc",     32'(addr_a), 32'h4C);
    check("hd_cnt_a",  32'(cnt_a), 32'd20);
    check("hd_cnt_b",  32'(cnt_b), 32'd15);
    jump = 1'b1; jump_target = 8'h10; branch_taken = 1'b1; branch_target = 8'h23;
    step(2);
    check("hj_pc",     32'(addr_a), 32'h4C);
    check("hj_halted", 32'(halted_a), 32'h1);
    check("hj_count",  32'(cnt_a), 32'd20);
    check("hj_mis",    32'(mis_a), 32'h0);

    // Reset out of HALT.
    rst_n = 1'b0;
    step(1);
    check("hr_halted", 32'(halted_a), 32'h0);
    check("hr_pc",     32'(addr_a), 32'h00);
    check("hr_count",  32'(cnt_a), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
